// File: rtl/seq_check_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_ctrl_pkg
//  Description : Shared types and defaults for the sequence-detector
//                self-test controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int SEQ_LEN_D     = 50;
    localparam int DET_LAT_D     = 1;
    localparam int HOLD_CYCLES_D = 50_000_000;

    // Index width for a run of n bits; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_check_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_check_ctrl_if
//  Description : Serial link between the self-test controller (master) and
//                the sequence detector under test (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_check_ctrl_if;

    logic det_din;
    logic det_clr;
    logic det_detect;

    modport master (
        output det_din,
        output det_clr,
        input  det_detect
    );

    modport slave (
        input  det_din,
        input  det_clr,
        output det_detect
    );

endinterface
`default_nettype wire

// File: rtl/seq_check_ctrl_err_led_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : err_led_stretch
//  Description : Pulse-in / level-out stretcher; each pulse (re)loads a
//                HOLD_CYCLES-long down-count that keeps the output high.
//  Revision    : 1.0 - initial release
// ============================================================================
module err_led_stretch
    import seq_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_D
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    output logic o_level
);

    localparam int                 c_CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(HOLD_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_pulse) begin
            r_cnt   <= c_RELOAD;
            r_level <= 1'b1;
        end else if (r_level) begin
            if (r_cnt == '0) begin
                r_level <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/seq_check_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_check_ctrl
//  Description : Self-test controller for the bit-serial sequence detector:
//                feeds a latched stimulus, checks det_detect against the
//                expected pattern and reports pass / error count / first index.
//                Optional macro ERR_LED_HOLD_EN stretches led_err to HOLD_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_check_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int SEQ_LEN     = SEQ_LEN_D,
    parameter int DET_LAT     = DET_LAT_D,
    parameter int HOLD_CYCLES = HOLD_CYCLES_D,
    parameter int ERR_W       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SEQ_LEN-1:0]          stim_seq,
    input  logic [SEQ_LEN-1:0]          exp_seq,
    seq_check_ctrl_if.master            det,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [ERR_W-1:0]            err_count,
    output logic [idx_w(SEQ_LEN)-1:0]   first_err_idx,
    output logic                        led_err
);

    localparam int                 c_IDX_W      = idx_w(SEQ_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST       = c_IDX_W'(SEQ_LEN - 1);
    localparam logic [2:0]         c_DRAIN_LAST = 3'(DET_LAT - 1);
    localparam logic [ERR_W-1:0]   c_ERR_MAX    = '1;

    if (SEQ_LEN < 2 || SEQ_LEN > 256) begin : g_bad_seq_len
        $error("SEQ_LEN must be in 2..256");
    end
    if (DET_LAT < 1 || DET_LAT > 4) begin : g_bad_det_lat
        $error("DET_LAT must be in 1..4");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end

    state_t               r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [2:0]           r_dcnt, w_dcnt_nxt;
    logic [SEQ_LEN-1:0]   r_stim_q, r_exp_q;

    logic                 w_det_din, w_det_clr, w_busy, w_done;
    logic                 r_det_din, r_det_clr, r_busy, r_done;

    logic                 r_pv   [DET_LAT];
    logic [c_IDX_W-1:0]   r_pidx [DET_LAT];
    logic                 w_mismatch;
    logic [ERR_W-1:0]     w_err_nxt, r_err;
    logic [c_IDX_W-1:0]   w_first_nxt, r_first;
    logic                 r_pass;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            IDLE:  if (start) w_state_nxt = FLUSH;
            FLUSH: begin
                w_state_nxt = RUN;
                w_idx_nxt   = '0;
            end
            RUN: begin
                if (r_idx == c_LAST) begin
                    w_state_nxt = DRAIN;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            DRAIN: begin
                if (r_dcnt == c_DRAIN_LAST) w_state_nxt = DONE;
                else                        w_dcnt_nxt  = r_dcnt + 1'b1;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded from next state, then registered) ----------------
    always_comb begin
        w_det_clr = (w_state_nxt == FLUSH);
        w_det_din = (w_state_nxt == RUN) ? r_stim_q[w_idx_nxt] : 1'b0;
        w_busy    = (w_state_nxt == FLUSH) || (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
        w_done    = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_det_din <= 1'b0;
            r_det_clr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_det_din <= w_det_din;
            r_det_clr <= w_det_clr;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    // Each RUN cycle pushes the index being driven; it emerges when det_detect answers it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DET_LAT; i++) begin
                r_pv[i]   <= 1'b0;
                r_pidx[i] <= '0;
            end
        end else begin
            r_pv[0]   <= (r_state == RUN);
            r_pidx[0] <= r_idx;
            for (int i = 1; i < DET_LAT; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_pidx[i] <= r_pidx[i-1];
            end
        end
    end

    assign w_mismatch = r_pv[DET_LAT-1] && (det.det_detect != r_exp_q[r_pidx[DET_LAT-1]]);

    always_comb begin
        w_err_nxt   = r_err;
        w_first_nxt = r_first;
        if (w_mismatch) begin
            if (r_err == '0)       w_first_nxt = r_pidx[DET_LAT-1];
            if (r_err != c_ERR_MAX) w_err_nxt  = r_err + 1'b1;
        end
    end

    // Shadow registers and results; a start clears the previous run's report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stim_q <= '0;
            r_exp_q  <= '0;
            r_err    <= '0;
            r_first  <= '0;
            r_pass   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_stim_q <= stim_seq;
            r_exp_q  <= exp_seq;
            r_err    <= '0;
            r_first  <= '0;
            r_pass   <= 1'b0;
        end else begin
            r_err   <= w_err_nxt;
            r_first <= w_first_nxt;
            if (w_state_nxt == DONE) r_pass <= (w_err_nxt == '0);
        end
    end

`ifdef ERR_LED_HOLD_EN
    err_led_stretch #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_err_led_stretch (
        .clk     (clk),
        .rst     (rst),
        .i_pulse (w_mismatch),
        .o_level (led_err)
    );
`else
    logic r_led_pulse;

    always_ff @(posedge clk) begin
        if (rst) r_led_pulse <= 1'b0;
        else     r_led_pulse <= w_mismatch;
    end

    assign led_err = r_led_pulse;
`endif

    assign det.det_din    = r_det_din;
    assign det.det_clr    = r_det_clr;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_idx  = r_first;

endmodule
`default_nettype wire

// File: tb/tb_seq_check_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_check_ctrl
//  Description : Directed bench for seq_check_ctrl with a 1-clock stub
//                detector and a run-timeline reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_check_ctrl;
    import seq_ctrl_pkg::*;

    localparam int L       = 8;
    localparam int D       = 1;
    localparam int EW      = 2;
    localparam int HOLD    = 10;
    localparam int ERR_MAX = (1 << EW) - 1;
    localparam int T_DONE  = L + D + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [L-1:0]  stim_seq = '0;
    logic [L-1:0]  exp_seq  = '0;
    logic          busy, done, pass, led_err;
    logic [EW-1:0] err_count;
    logic [2:0]    first_err_idx;

    int  checks   = 0;
    int  failures = 0;
    bit  chk_en   = 1'b0;

    seq_check_ctrl_if det_if ();

    seq_check_ctrl #(
        .SEQ_LEN     (L),
        .DET_LAT     (D),
        .HOLD_CYCLES (HOLD),
        .ERR_W       (EW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stim_seq      (stim_seq),
        .exp_seq       (exp_seq),
        .det           (det_if),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .led_err       (led_err)
    );

    always #5 clk = ~clk;

    // Stub detector: echoes det_din one clock later, cleared by det_clr.
    always @(posedge clk) begin
        if (rst || det_if.det_clr) det_if.det_detect <= 1'b0;
        else                       det_if.det_detect <= det_if.det_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model: position within a run ----------------
    int      m_t = -1;          // cycle number inside the run, -1 when idle
    logic [L-1:0] m_stim = '0, m_exp = '0;
    int      m_err = 0, m_first = 0, m_k;
    bit      m_pass = 1'b0;
    longint  cyc = 0, led_last = -1000;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_t = -1; m_err = 0; m_first = 0; m_pass = 1'b0; led_last = -1000;
        end else begin
            if (m_t == -1) begin
                if (start) begin
                    m_t = 1; m_stim = stim_seq; m_exp = exp_seq;
                    m_err = 0; m_first = 0; m_pass = 1'b0;
                end
            end else if (m_t == T_DONE) begin
                m_t = -1;
            end else begin
                m_t++;
            end
            if (m_t >= 1) begin
                // bit k sent in cycle k+2 is judged in cycle k+2+D, result visible one later
                m_k = m_t - 3 - D;
                if (m_k >= 0 && m_k < L && m_stim[m_k] != m_exp[m_k]) begin
                    if (m_err == 0) m_first = m_k;
                    if (m_err < ERR_MAX) m_err++;
                    led_last = cyc;
                end
                if (m_t == T_DONE) m_pass = (m_err == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    busy,    32'(m_t >= 1 && m_t <= L + D + 1));
            chk("det_clr", det_if.det_clr, 32'(m_t == 1));
            chk("det_din", det_if.det_din, 32'((m_t >= 2 && m_t <= L + 1) ? m_stim[m_t-2] : 1'b0));
            chk("done",    done,    32'(m_t == T_DONE));
            chk("pass",    pass,    32'(m_pass));
            chk("err_count",     err_count,     32'(m_err));
            chk("first_err_idx", first_err_idx, 32'(m_first));
`ifdef ERR_LED_HOLD_EN
            chk("led_err", led_err, 32'((cyc - led_last) < HOLD));
`else
            chk("led_err", led_err, 32'(cyc == led_last));
`endif
        end
    end

    // One start pulse from IDLE; literal expectations for the finished run.
    task automatic run(input logic [L-1:0] s, input logic [L-1:0] e, input bit ep,
                       input int ee, input int ef, input int nmis, input string nm);
        int n, nled;
        n = 0; nled = 0;
        stim_seq = s; exp_seq = e; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (led_err) nled++;
        end while (!done && n < 40);
        chk({nm, " done_cycle"}, n, T_DONE);
        chk({nm, " pass"}, pass, 32'(ep));
        chk({nm, " err_count"}, err_count, ee);
        chk({nm, " first_err_idx"}, first_err_idx, ef);
`ifndef ERR_LED_HOLD_EN
        chk({nm, " led_pulses"}, nled, nmis);
`endif
        @(posedge clk); #2;
    endtask

    initial begin
        int n, nd;
        repeat (2) @(posedge clk);
        #2 chk_en = 1'b1;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset err_count", err_count, 0);
        chk("reset det_clr", det_if.det_clr, 0);
        @(posedge clk); #2 rst = 1'b0;

        run(8'hA5, 8'hA5, 1'b1, 0, 0, 0, "basic");
        run(8'hA5, 8'hA4, 1'b0, 1, 0, 1, "locate");
        run(8'h00, 8'hFF, 1'b0, 3, 0, 8, "saturate");

        // idle gap so any stretched LED from the previous run has expired
        repeat (12) @(posedge clk);
        #2;
        run(8'h3C, 8'h18, 1'b0, 2, 2, 2, "two_errors");
`ifdef ERR_LED_HOLD_EN
        // mismatches judged 3 cycles apart: 6 high cycles inside the run, 7 after it
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!led_err) break;
            n++;
        end
        chk("hold tail", n, 7);
        @(posedge clk); #2;
`endif

        // reset in the 4th RUN cycle
        stim_seq = 8'hA5; exp_seq = 8'hA4; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-abort err_count", err_count, 1);
        #1 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort err_count", err_count, 0);
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort no done", nd, 0);
        @(posedge clk); #2;
        run(8'hA5, 8'hA5, 1'b1, 0, 0, 0, "after_abort");

        // start held high: inputs change mid-run, second run starts from IDLE
        stim_seq = 8'hA5; exp_seq = 8'hA4; start = 1'b1;
        @(posedge clk); #2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 4) begin stim_seq = 8'h0F; exp_seq = 8'h0F; end
        end while (!done && n < 40);
        chk("held done_cycle", n, T_DONE);
        chk("held err_count", err_count, 1);
        chk("held pass", pass, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) start = 1'b0;
        end while (!done && n < 40);
        chk("retrigger done_cycle", n, T_DONE + 1);
        chk("retrigger pass", pass, 1);
        chk("retrigger err_count", err_count, 0);

        repeat (4) @(posedge clk);
        #2 chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
